operand_entry_ctl: RTL and testbench

Keypad-side producer of the calculator's operand digits and display/control state. Consumes decoded key events, shifts BCD digits into operand A or B, and sequences `OP_A_IN` → `OP_B_IN` → `RESULT_OUT`. Drives `state`, `op_a1/op_a0/op_b1/op_b0` to the display-select logic and arithmetic unit, and pulses `calc_start` to launch the computation.

---
 rtl/operand_entry_ctl.sv | 164 ++++++++++++++++
 tb/tb_operand_entry_ctl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/operand_entry_ctl.sv
// Keypad operand entry and sequencing for the calculator: shifts BCD digits into A/B,
// walks OP_A_IN -> OP_B_IN -> RESULT_OUT. Optional backspace via `ENTRY_BACKSPACE_EN.
module operand_entry_ctl #(
   parameter int unsigned KEY_W      = 4,
   parameter int unsigned MAX_DIGITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic [KEY_W-1:0] key_code,
   output logic             key_ack,
   output logic             key_err,
   output logic [1:0]       state,
   output logic [3:0]       op_a1,
   output logic [3:0]       op_a0,
   output logic [3:0]       op_b1,
   output logic [3:0]       op_b0,
   output logic             calc_start
);

   typedef enum logic [1:0] {
      OP_A_IN    = 2'b00,
      OP_B_IN    = 2'b01,
      RESULT_OUT = 2'b10
   } state_e;

   localparam logic [KEY_W-1:0] K_DIG_MAX = KEY_W'(9);
   localparam logic [KEY_W-1:0] K_NEXT    = KEY_W'(4'hA);
   localparam logic [KEY_W-1:0] K_CLEAR   = KEY_W'(4'hC);
   localparam logic [KEY_W-1:0] K_ENTER   = KEY_W'(4'hF);
`ifdef ENTRY_BACKSPACE_EN
   localparam logic [KEY_W-1:0] K_BKSP    = KEY_W'(4'hE);
`endif
   localparam logic [1:0]       CNT_FULL  = 2'(MAX_DIGITS);

   state_e     state_q;
   logic [3:0] op_a1_q, op_a0_q, op_b1_q, op_b0_q;
   logic [1:0] cnt_a_q, cnt_b_q;
   logic       key_ack_q, key_err_q, calc_start_q;
   logic       is_digit;
   logic [3:0] digit;

   assign is_digit = (key_code <= K_DIG_MAX);
   assign digit    = key_code[3:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= OP_A_IN;
         op_a1_q      <= '0;
         op_a0_q      <= '0;
         op_b1_q      <= '0;
         op_b0_q      <= '0;
         cnt_a_q      <= '0;
         cnt_b_q      <= '0;
         key_ack_q    <= 1'b0;
         key_err_q    <= 1'b0;
         calc_start_q <= 1'b0;
      end else begin
         key_ack_q    <= key_valid;
         key_err_q    <= 1'b0;
         calc_start_q <= 1'b0;

         if (state_q != OP_A_IN && state_q != OP_B_IN && state_q != RESULT_OUT) begin
            // Illegal encoding: recover regardless of any key; a key seen here is reported as ignored.
            state_q   <= OP_A_IN;
            op_a1_q   <= '0;
            op_a0_q   <= '0;
            op_b1_q   <= '0;
            op_b0_q   <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            key_err_q <= key_valid;
         end else if (key_valid) begin
            if (is_digit) begin
               case (state_q)
                  OP_A_IN: begin
                     if (cnt_a_q < CNT_FULL) begin
                        op_a1_q <= op_a0_q;
                        op_a0_q <= digit;
                        cnt_a_q <= cnt_a_q + 2'd1;
                     end else begin
                        key_err_q <= 1'b1;
                     end
                  end
                  OP_B_IN: begin
                     if (cnt_b_q < CNT_FULL) begin
                        op_b1_q <= op_b0_q;
                        op_b0_q <= digit;
                        cnt_b_q <= cnt_b_q + 2'd1;
                     end else begin
                        key_err_q <= 1'b1;
                     end
                  end
                  default: begin
                     state_q <= OP_A_IN;
                     op_a1_q <= '0;
                     op_a0_q <= digit;
                     op_b1_q <= '0;
                     op_b0_q <= '0;
                     cnt_a_q <= 2'd1;
                     cnt_b_q <= '0;
                  end
               endcase
            end else begin
               case (key_code)
                  K_NEXT: begin
                     if (state_q == OP_A_IN) begin
                        state_q <= OP_B_IN;
                        op_b1_q <= '0;
                        op_b0_q <= '0;
                        cnt_b_q <= '0;
                     end else begin
                        key_err_q <= 1'b1;
                     end
                  end
                  K_ENTER: begin
                     if (state_q == OP_B_IN) begin
                        state_q      <= RESULT_OUT;
                        calc_start_q <= 1'b1;
                     end else begin
                        key_err_q <= 1'b1;
                     end
                  end
                  K_CLEAR: begin
                     state_q <= OP_A_IN;
                     op_a1_q <= '0;
                     op_a0_q <= '0;
                     op_b1_q <= '0;
                     op_b0_q <= '0;
                     cnt_a_q <= '0;
                     cnt_b_q <= '0;
                  end
`ifdef ENTRY_BACKSPACE_EN
                  K_BKSP: begin
                     if (state_q == OP_A_IN && cnt_a_q != 2'd0) begin
                        op_a0_q <= op_a1_q;
                        op_a1_q <= '0;
                        cnt_a_q <= cnt_a_q - 2'd1;
                     end else if (state_q == OP_B_IN && cnt_b_q != 2'd0) begin
                        op_b0_q <= op_b1_q;
                        op_b1_q <= '0;
                        cnt_b_q <= cnt_b_q - 2'd1;
                     end else begin
                        key_err_q <= 1'b1;
                     end
                  end
`endif
                  default: key_err_q <= 1'b1;
               endcase
            end
         end
      end
   end

   assign state      = state_q;
   assign op_a1      = op_a1_q;
   assign op_a0      = op_a0_q;
   assign op_b1      = op_b1_q;
   assign op_b0      = op_b0_q;
   assign key_ack    = key_ack_q;
   assign key_err    = key_err_q;
   assign calc_start = calc_start_q;

endmodule

// File: tb/tb_operand_entry_ctl.sv
// Directed table-driven bench for operand_entry_ctl, plus backspace sequences
// whose expectations follow `ENTRY_BACKSPACE_EN.
module tb_operand_entry_ctl;

   localparam logic [1:0] S_A = 2'b00;
   localparam logic [1:0] S_B = 2'b01;
   localparam logic [1:0] S_R = 2'b10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = '0;
   logic       key_ack, key_err, calc_start;
   logic [1:0] state;
   logic [3:0] op_a1, op_a0, op_b1, op_b0;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef struct {
      logic       rst;
      logic       kv;
      logic [3:0] code;
      logic [1:0] st;
      logic [3:0] a1, a0, b1, b0;
      logic       ack, err, cs;
   } vec_t;

   vec_t tv[$];

   operand_entry_ctl #(.KEY_W(4), .MAX_DIGITS(2)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_ack(key_ack), .key_err(key_err), .state(state),
      .op_a1(op_a1), .op_a0(op_a0), .op_b1(op_b1), .op_b0(op_b0),
      .calc_start(calc_start)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic kv, input logic [3:0] code,
                               input logic [1:0] st, input logic [3:0] a1, input logic [3:0] a0,
                               input logic [3:0] b1, input logic [3:0] b0,
                               input logic ack, input logic err, input logic cs);
      vec_t v;
      v.rst = r; v.kv = kv; v.code = code; v.st = st;
      v.a1 = a1; v.a0 = a0; v.b1 = b1; v.b0 = b0;
      v.ack = ack; v.err = err; v.cs = cs;
      return v;
   endfunction

   // Drive on the falling edge, sample 1 time unit after the following rising edge.
   task automatic step(input logic r, input logic kv, input logic [3:0] code);
      @(negedge clk);
      rst       = r;
      key_valid = kv;
      key_code  = code;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      key_valid = 1'b0;
   endtask

   task automatic check(input string name, input logic [1:0] st, input logic [3:0] a1,
                        input logic [3:0] a0, input logic [3:0] b1, input logic [3:0] b0,
                        input logic ack, input logic err, input logic cs);
      logic [20:0] act, exp;
      act = {state, op_a1, op_a0, op_b1, op_b0, key_ack, key_err, calc_start};
      exp = {st, a1, a0, b1, b0, ack, err, cs};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got st=%b A=%h%h B=%h%h ack=%b err=%b cs=%b, expected st=%b A=%h%h B=%h%h ack=%b err=%b cs=%b",
                  name, state, op_a1, op_a0, op_b1, op_b0, key_ack, key_err, calc_start,
                  st, a1, a0, b1, b0, ack, err, cs);
      end
   endtask

   initial begin
      //             rst kv  code   st   a1 a0 b1 b0 ack err cs
      tv.push_back(mk(1, 0, 4'h0, S_A, 0, 0, 0, 0, 0, 0, 0)); // reset
      tv.push_back(mk(1, 0, 4'h0, S_A, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 1, 4'h4, S_A, 0, 4, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h7, S_A, 4, 7, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 4'h0, S_A, 4, 7, 0, 0, 0, 0, 0)); // ack falls
      tv.push_back(mk(0, 1, 4'hC, S_A, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h1, S_A, 0, 1, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h2, S_A, 1, 2, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'hA, S_B, 1, 2, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h3, S_B, 1, 2, 0, 3, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h4, S_B, 1, 2, 3, 4, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'hF, S_R, 1, 2, 3, 4, 1, 0, 1)); // calc_start
      tv.push_back(mk(0, 0, 4'h0, S_R, 1, 2, 3, 4, 0, 0, 0)); // single cycle pulse
      tv.push_back(mk(0, 1, 4'hF, S_R, 1, 2, 3, 4, 1, 1, 0)); // F in result: no start
      tv.push_back(mk(0, 1, 4'hA, S_R, 1, 2, 3, 4, 1, 1, 0));
      tv.push_back(mk(0, 1, 4'h6, S_A, 0, 6, 0, 0, 1, 0, 0)); // restart
      tv.push_back(mk(0, 1, 4'hC, S_A, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h9, S_A, 0, 9, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h8, S_A, 9, 8, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h5, S_A, 9, 8, 0, 0, 1, 1, 0)); // overflow
      tv.push_back(mk(0, 1, 4'hF, S_A, 9, 8, 0, 0, 1, 1, 0));
      tv.push_back(mk(0, 1, 4'hB, S_A, 9, 8, 0, 0, 1, 1, 0)); // illegal
      tv.push_back(mk(0, 1, 4'hA, S_B, 9, 8, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h1, S_B, 9, 8, 0, 1, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'hD, S_B, 9, 8, 0, 1, 1, 1, 0));
      tv.push_back(mk(0, 1, 4'hA, S_B, 9, 8, 0, 1, 1, 1, 0));
      tv.push_back(mk(0, 1, 4'h2, S_B, 9, 8, 1, 2, 1, 0, 0));
      tv.push_back(mk(0, 1, 4'h7, S_B, 9, 8, 1, 2, 1, 1, 0)); // B overflow
      tv.push_back(mk(0, 1, 4'hC, S_A, 0, 0, 0, 0, 1, 0, 0)); // clear mid-B
      tv.push_back(mk(0, 1, 4'h3, S_A, 0, 3, 0, 0, 1, 0, 0));
      tv.push_back(mk(1, 1, 4'h5, S_A, 0, 0, 0, 0, 0, 0, 0)); // rst wins over key
      tv.push_back(mk(0, 0, 4'h0, S_A, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 1, 4'hA, S_B, 0, 0, 0, 0, 1, 0, 0)); // empty operands
      tv.push_back(mk(0, 1, 4'hF, S_R, 0, 0, 0, 0, 1, 0, 1));

      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].rst, tv[i].kv, tv[i].code);
         check($sformatf("vec%0d", i), tv[i].st, tv[i].a1, tv[i].a0, tv[i].b1, tv[i].b0,
               tv[i].ack, tv[i].err, tv[i].cs);
      end

      // Backspace sequences
      step(1, 0, 4'h0);
      step(0, 1, 4'h4);
      step(0, 1, 4'h7);
`ifdef ENTRY_BACKSPACE_EN
      step(0, 1, 4'hE);
      check("bksp_a1", S_A, 0, 4, 0, 0, 1, 0, 0);
      step(0, 1, 4'hE);
      check("bksp_a2", S_A, 0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 4'hE);
      check("bksp_empty", S_A, 0, 0, 0, 0, 1, 1, 0);
      step(0, 1, 4'h5);
      check("bksp_reentry", S_A, 0, 5, 0, 0, 1, 0, 0);
      step(0, 1, 4'hA);
      step(0, 1, 4'h8);
      step(0, 1, 4'h2);
      step(0, 1, 4'hE);
      check("bksp_b", S_B, 0, 5, 0, 8, 1, 0, 0);
      step(0, 1, 4'hF);
      step(0, 1, 4'hE);
      check("bksp_result", S_R, 0, 5, 0, 8, 1, 1, 0);
`else
      step(0, 1, 4'hE);
      check("bksp_off", S_A, 4, 7, 0, 0, 1, 1, 0);
      step(0, 1, 4'h1);
      check("bksp_off_full", S_A, 4, 7, 0, 0, 1, 1, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
